// File: rtl/truth_table_checker.sv
// Sweeps every input vector of an N-input combinational block, captures its truth
// table and compares it against a golden table latched when the sweep starts.
module truth_table_checker #(
    parameter int N    = 3,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [2**N-1:0] expected,
    input  logic            f_dut,
    output logic [N-1:0]    vec,
    output logic            busy,
    output logic            done,
    output logic [2**N-1:0] tt,
    output logic            pass,
    output logic [N:0]      err_cnt,
    output logic [N-1:0]    first_err,
    output logic            err_valid,
    output logic [1:0]      dbg_state
);

    localparam int             W         = 2**N;
    localparam logic [N-1:0]   LAST_VEC  = {N{1'b1}};
    localparam logic [7:0]     HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FIN} state_t;

    state_t       state;
    logic [7:0]   cnt;
    logic [W-1:0] exp_lat;
    logic         mismatch;

    assign mismatch  = (f_dut != exp_lat[vec]);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            exp_lat   <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt        <= '0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
            err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort outranks everything once busy; partial results are kept for inspection.
            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            exp_lat   <= expected;
                            tt        <= '0;
                            err_cnt   <= '0;
                            err_valid <= 1'b0;
                            first_err <= '0;
                            pass      <= 1'b0;
                            vec       <= '0;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            state     <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == HOLD_LAST) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        tt[vec] <= f_dut;
                        if (mismatch) begin
                            err_cnt <= err_cnt + 1'b1;
                            if (!err_valid) begin
                                first_err <= vec;
                                err_valid <= 1'b1;
                            end
                        end
                        // done and pass are raised on entry so they are valid during FIN.
                        if (vec == LAST_VEC) begin
                            state <= FIN;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0) && !mismatch;
                        end else begin
                            vec   <= vec + 1'b1;
                            cnt   <= '0;
                            state <= SETTLE;
                        end
                    end
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed and randomized sweeps of truth_table_checker (N=3/HOLD=1 and N=4/HOLD=3)
// against a truth-table reference model.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start3, abort3, f3, busy3, done3, pass3, err_valid3;
    logic [7:0]  exp3, tt3, func3;
    logic [2:0]  vec3, first_err3;
    logic [3:0]  err_cnt3;
    logic [1:0]  dbg3;

    logic        start4, abort4, f4, busy4, done4, pass4, err_valid4;
    logic [15:0] exp4, tt4, func4;
    logic [3:0]  vec4, first_err4;
    logic [4:0]  err_cnt4;
    logic [1:0]  dbg4;

    int vectors = 0;
    int miscompares = 0;
    int done3_pulses = 0;

    assign f3 = func3[vec3];
    assign f4 = func4[vec4];

    always @(posedge clk) if (done3) done3_pulses++;

    truth_table_checker #(.N(3), .HOLD(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .expected(exp3),
        .f_dut(f3), .vec(vec3), .busy(busy3), .done(done3), .tt(tt3), .pass(pass3),
        .err_cnt(err_cnt3), .first_err(first_err3), .err_valid(err_valid3), .dbg_state(dbg3)
    );

    truth_table_checker #(.N(4), .HOLD(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .expected(exp4),
        .f_dut(f4), .vec(vec4), .busy(busy4), .done(done4), .tt(tt4), .pass(pass4),
        .err_cnt(err_cnt4), .first_err(first_err4), .err_valid(err_valid4), .dbg_state(dbg4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: captured table is the function itself; errors are the differing bits.
    task automatic model(input logic [15:0] fn, input logic [15:0] ex, input int nv,
                         output int errs, output int first);
        errs  = 0;
        first = -1;
        for (int i = 0; i < nv; i++) begin
            if (fn[i] !== ex[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
    endtask

    task automatic wait_vec3(input logic [2:0] v);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (vec3 == v) found = 1'b1;
        end
        check("wait_vec3", 32'(found), 32'd1);
    endtask

    task automatic run3(input logic [7:0] fn, input logic [7:0] ex, input bit with_abort);
        int errs, first;
        bit got = 1'b0;
        model(16'(fn), 16'(ex), 8, errs, first);
        @(negedge clk);
        func3 = fn; exp3 = ex; start3 = 1'b1; abort3 = with_abort;
        @(negedge clk);
        start3 = 1'b0; abort3 = 1'b0; exp3 = ~ex;
        check("busy3_after_start", 32'(busy3), 32'd1);
        for (int k = 0; k <= 40 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 16) check("vec3_step", 32'(vec3), 32'(k / 2));
            if (done3) begin
                check("done3_latency", 32'(k), 32'd16);
                got = 1'b1;
            end
        end
        if (!got) check("done3_timeout", 32'd0, 32'd1);
        check("tt3", 32'(tt3), 32'(fn));
        check("pass3", 32'(pass3), 32'(errs == 0));
        check("err_cnt3", 32'(err_cnt3), 32'(errs));
        check("err_valid3", 32'(err_valid3), 32'(errs != 0));
        check("first_err3", 32'(first_err3), 32'(first));
        @(negedge clk);
        check("done3_pulse_end", 32'(done3), 32'd0);
        check("busy3_end", 32'(busy3), 32'd0);
    endtask

    task automatic run4(input logic [15:0] fn, input logic [15:0] ex);
        int errs, first;
        bit got = 1'b0;
        model(fn, ex, 16, errs, first);
        @(negedge clk);
        func4 = fn; exp4 = ex; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; exp4 = ~ex;
        for (int k = 0; k <= 120 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 64) check("vec4_step", 32'(vec4), 32'(k / 4));
            if (done4) begin
                check("done4_latency", 32'(k), 32'd64);
                got = 1'b1;
            end
        end
        if (!got) check("done4_timeout", 32'd0, 32'd1);
        check("tt4", 32'(tt4), 32'(fn));
        check("pass4", 32'(pass4), 32'(errs == 0));
        check("err_cnt4", 32'(err_cnt4), 32'(errs));
        check("err_valid4", 32'(err_valid4), 32'(errs != 0));
        check("first_err4", 32'(first_err4), 32'(first));
    endtask

    initial begin
        logic [7:0]  parity, fn, ex;
        logic [15:0] major, fn4, ex4;
        int          pulses;

        for (int i = 0; i < 8; i++)  parity[i] = ($countones(i) % 2) == 1;
        for (int i = 0; i < 16; i++) major[i]  = $countones(i >> 1) >= 2;

        rst_n = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; exp3 = '0; func3 = '0;
        start4 = 1'b0; abort4 = 1'b0; exp4 = '0; func4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_vec3", 32'(vec3), 32'd0);
        check("rst_tt3", 32'(tt3), 32'd0);
        check("rst_flags3", {28'd0, done3, pass3, err_valid3, 1'b0}, 32'd0);
        check("rst_err3", {25'd0, err_cnt3, first_err3}, 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        rst_n = 1'b1;

        // Parity function with a matching table, then single and all-bit mismatches.
        run3(parity, 8'h96, 1'b0);
        run3(parity, 8'h97, 1'b0);
        run3(8'h00, 8'hFF, 1'b0);
        // Abort together with start in IDLE must not prevent the sweep.
        run3(parity, 8'h96, 1'b1);

        for (int r = 0; r < 6; r++) begin
            fn = 8'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? fn : 8'($urandom);
            run3(fn, ex, 1'($urandom_range(0, 1)));
        end

        // Start re-pulsed mid-sweep is ignored; abort stops with partial results.
        @(negedge clk);
        func3 = parity; exp3 = 8'h96; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        pulses = done3_pulses;
        wait_vec3(3'd3);
        start3 = 1'b1; exp3 = 8'h00;
        @(negedge clk);
        start3 = 1'b0;
        check("no_restart_vec", 32'(vec3), 32'd3);
        wait_vec3(3'd5);
        abort3 = 1'b1;
        @(negedge clk);
        abort3 = 1'b0;
        check("abort_busy", 32'(busy3), 32'd0);
        check("abort_pass", 32'(pass3), 32'd0);
        check("abort_tt", 32'(tt3), {27'd0, parity[4:0]});
        check("abort_err_cnt", 32'(err_cnt3), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_vec_hold", 32'(vec3), 32'd5);
        check("abort_no_done", 32'(done3_pulses), 32'(pulses));

        // Asynchronous reset mid-sweep clears outputs without a clock edge.
        @(negedge clk);
        func3 = 8'hFF; exp3 = 8'h00; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        pulses = done3_pulses;
        wait_vec3(3'd4);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", 32'(busy3), 32'd0);
        check("areset_vec", 32'(vec3), 32'd0);
        check("areset_tt", 32'(tt3), 32'd0);
        check("areset_err_cnt", 32'(err_cnt3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("areset_no_done", 32'(done3_pulses), 32'(pulses));
        check("areset_idle", 32'(busy3), 32'd0);
        run3(parity, 8'h96, 1'b0);

        // Wider block: majority of the upper three inputs, then a random table.
        run4(major, major);
        fn4 = 16'($urandom);
        ex4 = 16'($urandom);
        run4(fn4, ex4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
